dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Two-port arbiter and access sequencer in front of the single-port data memory (64 x 32-bit words, combinational read, write on clock edge).
- Shares the memory between the core load/store port (port 0) and a debug/DMA port (port 1) using round-robin arbitration.
- Converts byte-enabled stores into read-modify-write sequences, because the memory only supports full-word writes.
- Registers read responses with a fixed latency and flags out-of-range accesses.

Parameters:
- DEPTH, 64, number of 32-bit words in the attached data memory; legal word index range is 0..DEPTH-1.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req0_valid / req1_valid  input  1  request present on port 0 / port 1.
- req0_ready / req1_ready  output  1  request accepted this cycle (valid & ready = handshake).
- req0_we / req1_we  input  1  1 = store, 0 = load.
- req0_addr / req1_addr  input  32  byte address; word index = addr[31:2]; addr[1:0] ignored.
- req0_wdata / req1_wdata  input  32  store data.
- req0_be / req1_be  input  4  byte enables for stores; be[i] selects bits 8i+7..8i; ignored on loads.
- rsp0_valid / rsp1_valid  output  1  one-cycle response pulse; requester must always accept it (no backpressure).
- rsp0_rdata / rsp1_rdata  output  32  load data; 0 for stores and errors.
- rsp0_err / rsp1_err  output  1  word index >= DEPTH.
- mem_read  output  1  drives the memory read enable.
- mem_write  output  1  drives the memory write enable.
- mem_addr  output  32  word index, {2'b00, addr[31:2]}.
- mem_wdata  output  32  word written to memory.
- mem_rdata  input  32  memory read data (combinational).
- stall_cnt  output  CNT_W  saturating count of cycles in which at least one valid request is not accepted.

Behaviour:
- Reset values (state after a cycle with reset=1):
  - State = IDLE, last_grant = 1 (so port 0 wins the first tie).
  - All rsp*_valid, rsp*_err and rsp*_rdata = 0.
  - stall_cnt = 0.
  - mem_read, mem_write, mem_addr and mem_wdata = 0.
  - Any in-flight operation is abandoned: no memory write and no response are issued for it.
- FSM states: IDLE, MERGE.
- IDLE, arbitration:
  - Only one valid: that port is granted.
  - Both valid: the port not equal to last_grant is granted.
  - The granted port's ready = 1 combinationally; the other port's ready = 0. last_grant updates to the granted port on handshake.
- IDLE, handshake by request type:
  - Out-of-range (index >= DEPTH): mem_read = mem_write = 0. Next cycle: rsp_valid = 1, err = 1, rdata = 0. Stay in IDLE.
  - Load: mem_read = 1 and mem_addr driven in the accept cycle; mem_rdata is captured. Next cycle: rsp_valid = 1 with the captured data. Latency = 1. Stay in IDLE.
  - Store with be = 4'b1111: mem_write = 1 with mem_wdata = wdata in the accept cycle. Next cycle: rsp_valid = 1. Stay in IDLE.
  - Store with be = 4'b0000: no memory access. Next cycle: rsp_valid = 1. Stay in IDLE.
  - Store with a partial be: mem_read = 1 in the accept cycle. Latch addr, wdata, be, the port id and the old word (mem_rdata). Go to MERGE.
- MERGE (exactly 1 cycle):
  - Both ready = 0.
  - mem_write = 1 to the latched address.
  - mem_wdata = per-byte select: wdata byte where be = 1, otherwise the old word's byte.
  - Next cycle: rsp_valid = 1 for the latched port. Return to IDLE.
  - Partial-store latency = 2 cycles; the port pair is blocked for 1 cycle.
- Back-to-back: in IDLE a new request may be accepted in the same cycle that the previous response is being presented. Full-word throughput = 1 access per cycle.
- Response pulses are asserted for one cycle only, on the port that issued the request; the other port's rsp_valid stays 0.
- stall_cnt:
  - Increments by 1 in any cycle where (req0_valid & ~req0_ready) | (req1_valid & ~req1_ready).
  - Saturates at 2^CNT_W - 1; never wraps.
- Requests must hold valid and payload stable until the handshake; the arbiter never drops an unacknowledged request.

Test Plan:
- Reset, then port0 stores addr 0x10, wdata 0xDEADBEEF, be = 1111; then port0 loads 0x10 -> mem_write = 1 with mem_addr = 4; load response one cycle after accept with rsp0_rdata = 0xDEADBEEF, err = 0.
- Word 4 = 0xDEADBEEF; port1 stores 0x10, wdata 0x000000AA, be = 0001 -> ready low in MERGE; mem_wdata = 0xDEADBEAA; rsp1_valid two cycles after accept; a subsequent load returns 0xDEADBEAA.
- Both ports hold valid loads continuously for 6 cycles after reset -> grants alternate 0,1,0,1,0,1; stall_cnt = 6.
- Port0 loads addr 0x100 (index 64, DEPTH = 64) -> no mem_read or mem_write; next cycle rsp0_valid = 1, rsp0_err = 1, rdata = 0.
- Assert reset during MERGE of a partial store -> no mem_write that cycle; no response issued; next state IDLE; stall_cnt = 0; port0 is granted first on the next tie.
- Force stall_cnt to 0xFFFE with CNT_W = 16, then hold contention for 3 cycles -> stall_cnt reaches 0xFFFF and stays there.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin two-port front end for a single-port 32-bit data memory.
// Partial-byte stores are sequenced as read-modify-write through a one-cycle MERGE state.
module dmem_arbiter #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic             req0_we,
    input  logic [31:0]      req0_addr,
    input  logic [31:0]      req0_wdata,
    input  logic [3:0]       req0_be,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic             req1_we,
    input  logic [31:0]      req1_addr,
    input  logic [31:0]      req1_wdata,
    input  logic [3:0]       req1_be,
    output logic             rsp0_valid,
    output logic [31:0]      rsp0_rdata,
    output logic             rsp0_err,
    output logic             rsp1_valid,
    output logic [31:0]      rsp1_rdata,
    output logic             rsp1_err,
    output logic             mem_read,
    output logic             mem_write,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam int unsigned IDX_W = 30;

    typedef enum logic {IDLE = 1'b0, MERGE = 1'b1} state_t;

    state_t           r_state;
    logic             r_last_grant;
    logic [IDX_W-1:0] r_idx;
    logic [31:0]      r_wdata;
    logic [3:0]       r_be;
    logic [31:0]      r_old;
    logic             r_port;
    logic [1:0]       r_rsp_valid;
    logic [1:0]       r_rsp_err;
    logic [31:0]      r_rsp0_rdata;
    logic [31:0]      r_rsp1_rdata;
    logic [CNT_W-1:0] r_stall;

    logic             w_idle;
    logic             w_merge;
    logic             w_any;
    logic             w_grant;
    logic             w_hs;
    logic             w_we;
    logic [31:0]      w_addr;
    logic [31:0]      w_wdata;
    logic [3:0]       w_be;
    logic [IDX_W-1:0] w_idx;
    logic             w_oob;
    logic             w_full;
    logic             w_none;
    logic             w_partial;
    logic             w_rd_acc;
    logic             w_wr_acc;
    logic [31:0]      w_merged;
    logic             w_stall;
    logic             w_unused;

    // Arbitration: a lone requester wins; on a tie the port that did not win last time wins.
    assign w_idle     = ~reset & (r_state == IDLE);
    assign w_merge    = ~reset & (r_state == MERGE);
    assign w_any      = req0_valid | req1_valid;
    assign w_grant    = (req0_valid & req1_valid) ? ~r_last_grant : req1_valid;
    assign w_hs       = w_idle & w_any;
    assign req0_ready = w_hs & ~w_grant;
    assign req1_ready = w_hs & w_grant;

    assign w_we      = w_grant ? req1_we    : req0_we;
    assign w_addr    = w_grant ? req1_addr  : req0_addr;
    assign w_wdata   = w_grant ? req1_wdata : req0_wdata;
    assign w_be      = w_grant ? req1_be    : req0_be;
    assign w_idx     = w_addr[31:2];
    assign w_oob     = 32'(w_idx) >= DEPTH;
    assign w_full    = w_we & (w_be == 4'hF);
    assign w_none    = w_we & (w_be == 4'h0);
    assign w_partial = w_we & ~w_full & ~w_none;
    assign w_unused  = ^{req0_addr[1:0], req1_addr[1:0]};

    // Old word bytes are kept wherever the latched byte enable is clear.
    always_comb begin
        w_merged = r_old;
        for (int b = 0; b < 4; b++) begin
            if (r_be[b]) w_merged[8*b +: 8] = r_wdata[8*b +: 8];
        end
    end

    assign w_rd_acc  = w_hs & ~w_oob & (~w_we | w_partial);
    assign w_wr_acc  = w_hs & ~w_oob & w_full;
    assign mem_read  = w_rd_acc;
    assign mem_write = w_merge | w_wr_acc;
    assign mem_addr  = w_merge ? {2'b00, r_idx} :
                       (w_rd_acc | w_wr_acc) ? {2'b00, w_idx} : 32'h0;
    assign mem_wdata = w_merge ? w_merged : (w_wr_acc ? w_wdata : 32'h0);
    assign w_stall   = (req0_valid & ~req0_ready) | (req1_valid & ~req1_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_idx        <= '0;
            r_wdata      <= '0;
            r_be         <= '0;
            r_old        <= '0;
            r_port       <= 1'b0;
            r_rsp_valid  <= 2'b00;
            r_rsp_err    <= 2'b00;
            r_rsp0_rdata <= '0;
            r_rsp1_rdata <= '0;
            r_stall      <= '0;
        end else begin
            r_rsp_valid  <= 2'b00;
            r_rsp_err    <= 2'b00;
            r_rsp0_rdata <= '0;
            r_rsp1_rdata <= '0;
            if (w_stall && (r_stall != {CNT_W{1'b1}})) r_stall <= r_stall + CNT_W'(1);
            case (r_state)
                IDLE: begin
                    if (w_hs) begin
                        r_last_grant <= w_grant;
                        if (w_partial && !w_oob) begin
                            r_state <= MERGE;
                            r_idx   <= w_idx;
                            r_wdata <= w_wdata;
                            r_be    <= w_be;
                            r_old   <= mem_rdata;
                            r_port  <= w_grant;
                        end else begin
                            r_rsp_valid[w_grant] <= 1'b1;
                            r_rsp_err[w_grant]   <= w_oob;
                            if (!w_we && !w_oob) begin
                                if (w_grant) r_rsp1_rdata <= mem_rdata;
                                else         r_rsp0_rdata <= mem_rdata;
                            end
                        end
                    end
                end
                MERGE: begin
                    r_state             <= IDLE;
                    r_rsp_valid[r_port] <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rsp0_valid = r_rsp_valid[0];
    assign rsp1_valid = r_rsp_valid[1];
    assign rsp0_err   = r_rsp_err[0];
    assign rsp1_err   = r_rsp_err[1];
    assign rsp0_rdata = r_rsp0_rdata;
    assign rsp1_rdata = r_rsp1_rdata;
    assign stall_cnt  = r_stall;

endmodule
